alu_stream_initiator: RTL

Upstream-facing initiator for the valid/ready ALU stream units. It accepts tagged operation requests, issues them in order to the ALU's `din` port, and buffers returned results with their tags. Results are presented on a response stream. Credit accounting guarantees buffer space for every in-flight operation, so it can hold the ALU's `dout_ready` high at all times outside reset.

---
 rtl/alu_stream_pkg.sv | 31 +++
 rtl/alu_sync_fifo.sv | 73 +++++++
 rtl/alu_stream_initiator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_stream_pkg.sv
// Shared definitions for the ALU valid/ready stream units: op codes and
// request/response field widths.
package alu_stream_pkg;

  localparam int MODE_W    = 4;
  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [MODE_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SLL  = 4'd1,
    OP_XOR  = 4'd4,
    OP_SRL  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SEQ  = 4'd8,
    OP_SNE  = 4'd9,
    OP_SUB  = 4'd10,
    OP_SRA  = 4'd11,
    OP_SLT  = 4'd12,
    OP_SGE  = 4'd13,
    OP_SLTU = 4'd14,
    OP_SGEU = 4'd15
  } alu_op_e;

  // A buffered response is the result word with its tag appended below it.
  function automatic int rsp_width(input int xlen, input int tag_w);
    return xlen + tag_w;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO: head is read straight from the storage registers, so a
// word written in one cycle is visible at the output only from the next.
module alu_sync_fifo
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == COUNT_MAX);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_stream_initiator.sv
// Initiator for the valid/ready ALU: issues tagged requests in order, keeps
// tags in flight, and buffers results so the ALU output is never stalled.
module alu_stream_initiator
  import alu_stream_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = TAG_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [MODE_W-1:0]          req_mode,
  input  logic [XLEN-1:0]            req_arg1,
  input  logic [XLEN-1:0]            req_arg2,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [MODE_W-1:0]          alu_mode,
  output logic [XLEN-1:0]            alu_arg1,
  output logic [XLEN-1:0]            alu_arg2,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [XLEN-1:0]            res_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [XLEN-1:0]            rsp_result,
  output logic [TAG_WIDTH-1:0]       rsp_tag,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = rsp_width(XLEN, TAG_WIDTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  logic [CW-1:0]        credits_q, credits_d;
  logic                 alu_valid_q, alu_valid_d;
  logic [MODE_W-1:0]    alu_mode_q, alu_mode_d;
  logic [XLEN-1:0]      alu_arg1_q, alu_arg1_d;
  logic [XLEN-1:0]      alu_arg2_q, alu_arg2_d;
  logic [TAG_WIDTH-1:0] alu_tag_q, alu_tag_d;
  logic                 err_q, err_d;

  logic                 req_hs, alu_hs, rsp_hs;
  logic                 res_take, res_orphan;
  logic                 tq_full, tq_empty;
  logic [CW-1:0]        tq_count;
  logic [TAG_WIDTH-1:0] tq_dout;
  logic                 rf_full, rf_empty;
  logic [CW-1:0]        rf_count;
  logic [RW-1:0]        rf_din, rf_dout;

  // Credits alone gate acceptance; FIFO space is implied by them, so the
  // ALU result port can stay ready whenever we are out of reset.
  assign req_ready  = !reset && (credits_q != '0) && (!alu_valid_q || alu_ready);
  assign req_hs     = req_valid && req_ready;
  assign alu_hs     = alu_valid_q && alu_ready && !reset;
  assign res_ready  = !reset;
  assign res_take   = res_valid && !reset && !tq_empty;
  assign res_orphan = res_valid && !reset && tq_empty;
  assign rsp_valid  = !rf_empty;
  assign rsp_hs     = rsp_valid && rsp_ready && !reset;

  assign alu_valid  = alu_valid_q;
  assign alu_mode   = alu_mode_q;
  assign alu_arg1   = alu_arg1_q;
  assign alu_arg2   = alu_arg2_q;
  assign credits    = credits_q;
  assign err        = err_q;

  assign rf_din                = {res_result, tq_dout};
  assign {rsp_result, rsp_tag} = rf_dout;

  alu_sync_fifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (DEPTH)
  ) u_tag_queue (
    .clock (clock),
    .reset (reset),
    .push  (alu_hs),
    .din   (alu_tag_q),
    .pop   (res_take),
    .dout  (tq_dout),
    .full  (tq_full),
    .empty (tq_empty),
    .count (tq_count)
  );

  alu_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clock (clock),
    .reset (reset),
    .push  (res_take),
    .din   (rf_din),
    .pop   (rsp_hs),
    .dout  (rf_dout),
    .full  (rf_full),
    .empty (rf_empty),
    .count (rf_count)
  );

  // Occupancy and full flags are informational here; credits already bound both queues.
  logic unused_fifo_status;
  assign unused_fifo_status = ^{tq_full, tq_count, rf_full, rf_count};

  always_comb begin
    alu_valid_d = alu_valid_q;
    alu_mode_d  = alu_mode_q;
    alu_arg1_d  = alu_arg1_q;
    alu_arg2_d  = alu_arg2_q;
    alu_tag_d   = alu_tag_q;
    if (req_hs) begin
      alu_valid_d = 1'b1;
      alu_mode_d  = req_mode;
      alu_arg1_d  = req_arg1;
      alu_arg2_d  = req_arg2;
      alu_tag_d   = req_tag;
    end else if (alu_hs) begin
      alu_valid_d = 1'b0;
    end

    credits_d = credits_q;
    if (req_hs && !rsp_hs && (credits_q != '0)) begin
      credits_d = credits_q - CRED_ONE;
    end else if (rsp_hs && !req_hs && (credits_q != CRED_MAX)) begin
      credits_d = credits_q + CRED_ONE;
    end

    err_d = err_q || res_orphan;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_valid_q <= 1'b0;
      alu_mode_q  <= '0;
      alu_arg1_q  <= '0;
      alu_arg2_q  <= '0;
      alu_tag_q   <= '0;
      credits_q   <= CRED_MAX;
      err_q       <= 1'b0;
    end else begin
      alu_valid_q <= alu_valid_d;
      alu_mode_q  <= alu_mode_d;
      alu_arg1_q  <= alu_arg1_d;
      alu_arg2_q  <= alu_arg2_d;
      alu_tag_q   <= alu_tag_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
    end
  end

endmodule
